// File: rtl/piccolo_pkg.sv
// Shared definitions for the Piccolo round-permutation datapath.
// Provides the per-beat operation encoding and the lane maps used by the
// forward and inverse round permutations (out lane i <- in lane MAP[i]).
package piccolo_pkg;

    typedef enum logic [1:0] {
        RP_FWD = 2'b00,
        RP_INV = 2'b01,
        RP_BYP = 2'b10,
        RP_RSV = 2'b11
    } rp_mode_t;

    localparam int RP_FWD_MAP[8] = '{2, 7, 4, 1, 6, 3, 0, 5};
    localparam int RP_INV_MAP[8] = '{6, 3, 0, 5, 2, 7, 4, 1};

endpackage

// File: rtl/rp_fifo.sv
// Generic synchronous FIFO with a registered head output.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   push, pop  write/read strobes (push ignored when full, pop when empty)
//   din        write data
//   dout       head entry, registered; reads 0 whenever the FIFO is empty
//   count      current occupancy (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module rp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);
    import piccolo_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] dout_reg;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full        = (count_reg == CW'(DEPTH));
    assign empty       = (count_reg == '0);
    assign do_push     = push && !full;
    assign do_pop      = pop && !empty;
    assign rd_ptr_next = rd_ptr_reg + AW'(1);

    // Storage carries no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_next;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

    // The head is kept in its own register so outputs never come from a
    // combinational path. When the FIFO holds at most one entry after this
    // edge the head is taken from din directly, because that entry is
    // being written this same cycle and is not readable from mem yet.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_reg <= '0;
        end else if (do_pop && (count_reg == CW'(1))) begin
            dout_reg <= do_push ? din : '0;
        end else if (empty && do_push) begin
            dout_reg <= din;
        end else if (do_pop) begin
            dout_reg <= mem[rd_ptr_next];
        end
    end

    assign dout  = dout_reg;
    assign count = count_reg;

endmodule

// File: rtl/piccolo_rp_stream.sv
// Piccolo round-permutation stream unit.
// Applies forward / inverse / bypass round permutation per beat and queues
// {err, tag, data} in an output FIFO.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              input handshake
//   in_data, in_mode, in_tag       state word, operation, sideband tag
//   out_valid/out_ready            output handshake
//   out_data, out_tag, out_err     head beat; err marks reserved mode
//   count                          FIFO occupancy
module piccolo_rp_stream #(
    parameter int LANE_W     = 8,
    parameter int FIFO_DEPTH = 2,
    parameter int TAG_W      = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [8*LANE_W-1:0]           in_data,
    input  logic [1:0]                    in_mode,
    input  logic [TAG_W-1:0]              in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [8*LANE_W-1:0]           out_data,
    output logic [TAG_W-1:0]              out_tag,
    output logic                          out_err,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    import piccolo_pkg::*;

    localparam int BW = 8 * LANE_W;
    localparam int FW = BW + TAG_W + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rp_mode_t         mode;
    logic [BW-1:0]    fwd_data;
    logic [BW-1:0]    inv_data;
    logic [BW-1:0]    perm_data;
    logic             perm_err;
    logic [FW-1:0]    fifo_din;
    logic [FW-1:0]    fifo_dout;
    logic [CW-1:0]    fifo_count;
    logic             push;
    logic             pop;

    assign mode = rp_mode_t'(in_mode);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign fwd_data[LANE_W*gi +: LANE_W] = in_data[LANE_W*RP_FWD_MAP[gi] +: LANE_W];
            assign inv_data[LANE_W*gi +: LANE_W] = in_data[LANE_W*RP_INV_MAP[gi] +: LANE_W];
        end
    endgenerate

    // Reserved mode passes data through unchanged but flags the beat.
    always_comb begin
        perm_data = in_data;
        perm_err  = 1'b0;
        case (mode)
            RP_FWD:  perm_data = fwd_data;
            RP_INV:  perm_data = inv_data;
            RP_BYP:  perm_data = in_data;
            default: perm_err  = 1'b1;
        endcase
    end

    // Handshakes depend on occupancy only, never on out_ready.
    assign in_ready  = (fifo_count != CW'(FIFO_DEPTH));
    assign out_valid = (fifo_count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign fifo_din  = {perm_err, in_tag, perm_data};

    rp_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign {out_err, out_tag, out_data} = fifo_dout;
    assign count = fifo_count;

endmodule

// File: tb/tb_piccolo_rp_stream.sv
module tb_piccolo_rp_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_tag;
    logic        out_err;
    logic [1:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    piccolo_rp_stream #(
        .LANE_W     (8),
        .FIFO_DEPTH (2),
        .TAG_W      (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err),
        .count     (count)
    );

    typedef struct {
        logic [63:0] din;
        logic [1:0]  mode;
        logic [4:0]  tag;
        logic [63:0] exp;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [63:0] q[$];
    logic [63:0] w;
    logic [63:0] mid;
    logic [63:0] b1, b2, b3;
    bit          pushing;
    bit          popping;

    initial begin
        vecs[0] = '{64'h0706050403020100, 2'b00, 5'd3,  64'h0500030601040702, 1'b0};
        vecs[1] = '{64'h0500030601040702, 2'b01, 5'd4,  64'h0706050403020100, 1'b0};
        vecs[2] = '{64'h0123456789ABCDEF, 2'b10, 5'd5,  64'h0123456789ABCDEF, 1'b0};
        vecs[3] = '{64'h0123456789ABCDEF, 2'b11, 5'd6,  64'h0123456789ABCDEF, 1'b1};
        vecs[4] = '{64'h0123456789ABCDEF, 2'b00, 5'd31, 64'h45EF8923CD6701AB, 1'b0};
        vecs[5] = '{64'h0706050403020100, 2'b01, 5'd0,  64'h0104070205000306, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 2'b00; in_tag = '0; out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_data", out_data, 64'd0);
        chk("reset_out_tag_err", 64'({out_err, out_tag}), 64'd0);

        // Table-driven single beats: one-cycle latency into an empty FIFO.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = vecs[i].din; in_mode = vecs[i].mode; in_tag = vecs[i].tag;
            step();
            in_valid = 1'b0;
            $display("vec %0d: mode=%0d in=%h out=%h tag=%0d err=%0d",
                     i, vecs[i].mode, vecs[i].din, out_data, out_tag, out_err);
            chk("vec_valid", 64'(out_valid), 64'd1);
            chk("vec_data", out_data, vecs[i].exp);
            chk("vec_tag", 64'(out_tag), 64'(vecs[i].tag));
            chk("vec_err", 64'(out_err), 64'(vecs[i].exp_err));
            chk("vec_count", 64'(count), 64'd1);
            step();
            chk("vec_drain", 64'(count), 64'd0);
        end

        // Random forward-then-inverse round trips.
        for (int i = 0; i < 1000; i++) begin
            w = {$urandom, $urandom};
            in_valid = 1'b1; in_data = w; in_mode = 2'b00; in_tag = 5'(i);
            step();
            mid = out_data;
            in_data = mid; in_mode = 2'b01;
            step();
            in_valid = 1'b0;
            $display("rt %0d: in=%h fwd=%h back=%h", i, w, mid, out_data);
            chk("roundtrip", out_data, w);
            step();
        end

        // Backpressure with a depth-2 FIFO.
        b1 = 64'h1111111111111111; b2 = 64'h2222222222222222; b3 = 64'h3333333333333333;
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 2'b10; in_data = b1; in_tag = 5'd1;
        step();
        chk("bp_count1", 64'(count), 64'd1);
        in_data = b2; in_tag = 5'd2;
        step();
        chk("bp_count2", 64'(count), 64'd2);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_head1", out_data, b1);
        in_data = b3; in_tag = 5'd3;
        step();
        $display("bp: offered beat3 while full, count=%0d head=%h", count, out_data);
        chk("bp_full_ignored", 64'(count), 64'd2);
        chk("bp_head1_stable", out_data, b1);
        chk("bp_tag1_stable", 64'(out_tag), 64'd1);
        out_ready = 1'b1;
        step();
        $display("bp: released, head=%h count=%0d", out_data, count);
        chk("bp_head2", out_data, b2);
        chk("bp_count_after_pop", 64'(count), 64'd1);
        chk("bp_in_ready_back", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        $display("bp: head=%h tag=%0d", out_data, out_tag);
        chk("bp_head3", out_data, b3);
        chk("bp_tag3", 64'(out_tag), 64'd3);
        step();
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Streaming with simultaneous push/pop at count 1.
        q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 21; i++) begin
            in_valid = 1'b1; in_mode = 2'b10; in_tag = 5'(i);
            in_data = {32'hA5A5_0000 + 32'(i), $urandom};
            popping = (q.size() != 0);
            pushing = (q.size() < 2);
            if (pushing) q.push_back(in_data);
            step();
            if (popping) void'(q.pop_front());
            $display("stream %0d: count=%0d head=%h", i, count, out_data);
            chk("stream_count", 64'(count), 64'd1);
            chk("stream_data", out_data, q[0]);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drain", 64'(count), 64'd0);

        // Mid-operation reset at count 2; reset wins over push and pop.
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 2'b00; in_data = 64'hDEADBEEFCAFEF00D; in_tag = 5'd7;
        step();
        step();
        chk("mr_count2", 64'(count), 64'd2);
        rst = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        $display("mid reset: count=%0d valid=%0d data=%h", count, out_valid, out_data);
        chk("mr_count", 64'(count), 64'd0);
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_out_data", out_data, 64'd0);
        chk("mr_tag_err", 64'({out_err, out_tag}), 64'd0);
        chk("mr_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_mode = 2'b11; in_data = 64'h0F0E0D0C0B0A0908; in_tag = 5'd9;
        step();
        in_valid = 1'b0;
        $display("post reset push: data=%h tag=%0d err=%0d", out_data, out_tag, out_err);
        chk("mr_push_data", out_data, 64'h0F0E0D0C0B0A0908);
        chk("mr_push_tag", 64'(out_tag), 64'd9);
        chk("mr_push_err", 64'(out_err), 64'd1);
        chk("mr_push_count", 64'(count), 64'd1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
